// File: rtl/shift_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : shift_reg_sequencer
//  Purpose  : Command-driven controller for a WIDTH-bit universal shift
//             register. It runs LOAD, SHL, SHR and ROL operations with a
//             step count, and signals completion with a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       op_lat;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] data_lat;

  // The final EXEC cycle is the one that does the last step, or the single
  // no-op / load cycle for LOAD and count==0.
  logic last_exec;
  assign last_exec = (op_lat == OP_LOAD) || (rem == CNT_ONE) || (rem == CNT_ZERO);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_EXEC;
      S_EXEC:  if (last_exec) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  cmd_ready = 1'b1;
      S_EXEC:  busy = 1'b1;
      S_DONE:  begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // Command latches and shift datapath; one step per EXEC edge while steps remain.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_lat   <= OP_LOAD;
      rem      <= CNT_ZERO;
      data_lat <= {WIDTH{1'b0}};
      q        <= {WIDTH{1'b0}};
      ser_out  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_lat   <= cmd_op;
            rem      <= cmd_count;
            data_lat <= cmd_data;
          end
        end
        S_EXEC: begin
          if (op_lat == OP_LOAD) begin
            q <= data_lat;
          end else if (rem != CNT_ZERO) begin
            rem <= rem - CNT_ONE;
            case (op_lat)
              OP_SHL: begin
                q       <= {q[WIDTH-2:0], ser_in};
                ser_out <= q[WIDTH-1];
              end
              OP_SHR: begin
                q       <= {ser_in, q[WIDTH-1:1]};
                ser_out <= q[0];
              end
              OP_ROL: begin
                q       <= {q[WIDTH-2:0], q[WIDTH-1]};
                ser_out <= q[WIDTH-1];
              end
              default: q <= q;
            endcase
          end
        end
        default: q <= q;
      endcase
    end
  end

endmodule
`default_nettype wire
